// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants and types for the instruction-memory writer.
// Opcodes cover the four formats the program loader can emit.
package rv_isa_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FMT_LOAD   = 2'd0,
    FMT_STORE  = 2'd1,
    FMT_RTYPE  = 2'd2,
    FMT_BRANCH = 2'd3
  } fmt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/instr_mem_writer_if.sv
// Request and IMEM write bus between a program source and instr_mem_writer.
// master = program source / IMEM side, slave = the writer.
interface instr_mem_writer_if
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              req_valid;
  logic              req_ready;
  fmt_t              req_fmt;
  logic [2:0]        req_funct3;
  logic              req_funct7b5;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [12:0]       req_imm;
  logic              req_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, req_valid, req_fmt, req_funct3, req_funct7b5,
           req_rd, req_rs1, req_rs2, req_imm, req_last,
    input  req_ready, imem_we, imem_addr, imem_wdata, busy, done, err
  );

  modport slave (
    input  start, req_valid, req_fmt, req_funct3, req_funct7b5,
           req_rd, req_rs1, req_rs2, req_imm, req_last,
    output req_ready, imem_we, imem_addr, imem_wdata, busy, done, err
  );

endinterface

// File: rtl/instr_pack.sv
// Combinational packer: instruction format + fields -> 32-bit RV32I word.
// Also flags a branch offset with bit 0 set, which the encoding cannot represent.
module instr_pack
  import rv_isa_pkg::*;
(
  input  fmt_t        i_fmt,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7b5,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [12:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_misaligned
);

  always_comb begin
    o_word       = '0;
    o_misaligned = 1'b0;
    case (i_fmt)
      FMT_LOAD:
        o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
      FMT_STORE:
        o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
      FMT_RTYPE:
        o_word = {1'b0, i_funct7b5, 5'b00000, i_rs2, i_rs1, i_funct3, i_rd, OP_RTYPE};
      FMT_BRANCH: begin
        // imm[0] is implicitly zero in B-type; it is dropped, not rounded
        o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                  i_imm[4:1], i_imm[11], OP_BRANCH};
        o_misaligned = i_imm[0];
      end
      default: o_word = '0;
    endcase
  end

endmodule

// File: rtl/instr_mem_writer.sv
// Loads a program into IMEM: accepts encoded-instruction requests and writes the
// packed words to consecutive word addresses, one registered stage after acceptance.
module instr_mem_writer
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 6
)(
  input  logic               clk,
  input  logic               rst,
  instr_mem_writer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_req_ready;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [31:0]       w_word;
  logic              w_misaligned;
  logic              w_accept;
  logic              w_at_end;
  logic              w_finish;
  logic              w_trunc;

  instr_pack u_pack (
    .i_fmt        (bus.req_fmt),
    .i_funct3     (bus.req_funct3),
    .i_funct7b5   (bus.req_funct7b5),
    .i_rd         (bus.req_rd),
    .i_rs1        (bus.req_rs1),
    .i_rs2        (bus.req_rs2),
    .i_imm        (bus.req_imm),
    .o_word       (w_word),
    .o_misaligned (w_misaligned)
  );

  // r_req_ready is only ever set while in LOAD, so it doubles as the state qualifier
  assign w_accept = r_req_ready & bus.req_valid;
  assign w_at_end = (r_wr_ptr == PTR_MAX);
  assign w_finish = w_accept & (bus.req_last | w_at_end);
  assign w_trunc  = w_accept & ~bus.req_last & w_at_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_req_ready  <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state     <= ST_LOAD;
            r_wr_ptr    <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= r_wr_ptr;
            r_imem_wdata <= w_word;
            // pointer saturates so a truncated load never wraps onto address 0
            if (!w_at_end) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_misaligned || w_trunc) r_err <= 1'b1;
            if (w_finish) begin
              r_state     <= ST_DONE;
              r_req_ready <= 1'b0;
              r_done      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_instr_mem_writer.sv
// Scoreboard bench for instr_mem_writer: one ADDR_W=6 instance for normal loads and
// one ADDR_W=2 instance for truncation; expected writes are queued and checked by monitors.
module tb_instr_mem_writer;
  import rv_isa_pkg::*;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        done;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_mem_writer_if #(.ADDR_W(6)) bus6 ();
  instr_mem_writer_if #(.ADDR_W(2)) bus2 ();

  instr_mem_writer #(.ADDR_W(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));
  instr_mem_writer #(.ADDR_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  fmt_t        t_fmt = FMT_LOAD;
  logic [2:0]  t_f3 = '0;
  logic        t_f7b5 = 1'b0;
  logic [4:0]  t_rd = '0, t_rs1 = '0, t_rs2 = '0;
  logic [12:0] t_imm = '0;
  logic        t_last = 1'b0;
  logic        t_valid6 = 1'b0, t_valid2 = 1'b0;
  logic        t_start6 = 1'b0, t_start2 = 1'b0;

  assign bus6.start = t_start6;         assign bus2.start = t_start2;
  assign bus6.req_valid = t_valid6;     assign bus2.req_valid = t_valid2;
  assign bus6.req_fmt = t_fmt;          assign bus2.req_fmt = t_fmt;
  assign bus6.req_funct3 = t_f3;        assign bus2.req_funct3 = t_f3;
  assign bus6.req_funct7b5 = t_f7b5;    assign bus2.req_funct7b5 = t_f7b5;
  assign bus6.req_rd = t_rd;            assign bus2.req_rd = t_rd;
  assign bus6.req_rs1 = t_rs1;          assign bus2.req_rs1 = t_rs1;
  assign bus6.req_rs2 = t_rs2;          assign bus2.req_rs2 = t_rs2;
  assign bus6.req_imm = t_imm;          assign bus2.req_imm = t_imm;
  assign bus6.req_last = t_last;        assign bus2.req_last = t_last;

  exp_t q6[$];
  exp_t q2[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_wr6 = 0, n_acc6 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus6.imem_we === 1'b1) begin
      n_wr6++;
      if (q6.size() == 0) chk("dut6_unexpected_write", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q6.pop_front();
        chk("dut6_addr",  {26'd0, bus6.imem_addr}, {26'd0, e.addr});
        chk("dut6_wdata", bus6.imem_wdata, e.wdata);
        chk("dut6_done",  {31'd0, bus6.done}, {31'd0, e.done});
        chk("dut6_err",   {31'd0, bus6.err},  {31'd0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    if (bus2.imem_we === 1'b1) begin
      if (q2.size() == 0) chk("dut2_unexpected_write", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2_addr",  {30'd0, bus2.imem_addr}, {26'd0, e.addr});
        chk("dut2_wdata", bus2.imem_wdata, e.wdata);
        chk("dut2_done",  {31'd0, bus2.done}, {31'd0, e.done});
        chk("dut2_err",   {31'd0, bus2.err},  {31'd0, e.err});
      end
    end
  end

  task automatic do_start(input bit sel);
    if (sel) t_start2 = 1'b1; else t_start6 = 1'b1;
    @(posedge clk); @(negedge clk);
    t_start2 = 1'b0; t_start6 = 1'b0;
  endtask

  // Offers one request for up to max_cyc cycles; pushes the expected write when accepted.
  task automatic send(input bit sel, input fmt_t fmt, input logic [2:0] f3, input logic f7b5,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [12:0] imm, input logic last, input int max_cyc,
                      input logic [5:0] e_addr, input logic [31:0] e_word,
                      input logic e_done, input logic e_err, output bit acc);
    exp_t e;
    t_fmt = fmt; t_f3 = f3; t_f7b5 = f7b5; t_rd = rd; t_rs1 = rs1; t_rs2 = rs2;
    t_imm = imm; t_last = last;
    if (sel) t_valid2 = 1'b1; else t_valid6 = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < max_cyc && !acc; i++) begin
      if ((sel ? bus2.req_ready : bus6.req_ready) === 1'b1) begin
        acc = 1'b1;
        e.addr = e_addr; e.wdata = e_word; e.done = e_done; e.err = e_err;
        if (sel) q2.push_back(e); else begin q6.push_back(e); n_acc6++; end
      end
      @(posedge clk); @(negedge clk);
    end
    t_valid2 = 1'b0; t_valid6 = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_we"},    {31'd0, bus6.imem_we}, 32'd0);
    chk({tag, "_addr"},  {26'd0, bus6.imem_addr}, 32'd0);
    chk({tag, "_wdata"}, bus6.imem_wdata, 32'd0);
    chk({tag, "_ready"}, {31'd0, bus6.req_ready}, 32'd0);
    chk({tag, "_busy"},  {31'd0, bus6.busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, bus6.done}, 32'd0);
    chk({tag, "_err"},   {31'd0, bus6.err}, 32'd0);
  endtask

  initial begin
    bit acc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset6");
    chk("reset2_we",  {31'd0, bus2.imem_we}, 32'd0);
    chk("reset2_err", {31'd0, bus2.err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single LOAD program
    do_start(1'b0);
    chk("busy_after_start", {31'd0, bus6.busy}, 32'd1);
    chk("ready_after_start", {31'd0, bus6.req_ready}, 32'd1);
    send(1'b0, FMT_LOAD, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b1, 10,
         6'd0, 32'h00812283, 1'b1, 1'b0, acc);
    chk("load_accept", {31'd0, acc}, 32'd1);
    chk("ready_drop_after_last", {31'd0, bus6.req_ready}, 32'd0);
    @(negedge clk);
    chk("busy_after_done", {31'd0, bus6.busy}, 32'd0);

    // back-to-back STORE / RTYPE / RTYPE(sub)
    do_start(1'b0);
    send(1'b0, FMT_STORE, 3'b010, 1'b0, 5'd0, 5'd2, 5'd6, 13'd12, 1'b0, 10,
         6'd0, 32'h00612623, 1'b0, 1'b0, acc);
    send(1'b0, FMT_RTYPE, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0, 10,
         6'd1, 32'h003100B3, 1'b0, 1'b0, acc);
    send(1'b0, FMT_RTYPE, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 13'd0, 1'b1, 10,
         6'd2, 32'h403100B3, 1'b1, 1'b0, acc);
    repeat (2) @(negedge clk);

    // branch: aligned then misaligned offset
    do_start(1'b0);
    send(1'b0, FMT_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b0, 10,
         6'd0, 32'hFE208CE3, 1'b0, 1'b0, acc);
    send(1'b0, FMT_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FF9, 1'b1, 10,
         6'd1, 32'hFE208CE3, 1'b1, 1'b1, acc);
    @(negedge clk);
    chk("err_sticky_in_idle", {31'd0, bus6.err}, 32'd1);

    // start clears err; start during LOAD is ignored
    do_start(1'b0);
    chk("err_cleared_by_start", {31'd0, bus6.err}, 32'd0);
    send(1'b0, FMT_LOAD, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b0, 10,
         6'd0, 32'h00812283, 1'b0, 1'b0, acc);
    do_start(1'b0);
    send(1'b0, FMT_STORE, 3'b010, 1'b0, 5'd0, 5'd2, 5'd6, 13'd12, 1'b1, 10,
         6'd1, 32'h00612623, 1'b1, 1'b0, acc);
    repeat (2) @(negedge clk);

    // truncation on the 4-word instance
    do_start(1'b1);
    for (int k = 0; k < 4; k++) begin
      send(1'b1, FMT_LOAD, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b0, 10,
           6'(k), 32'h00812283, (k == 3), (k == 3), acc);
      chk("trunc_accept", {31'd0, acc}, 32'd1);
    end
    chk("trunc_ready_low", {31'd0, bus2.req_ready}, 32'd0);
    chk("trunc_err", {31'd0, bus2.err}, 32'd1);
    send(1'b1, FMT_LOAD, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b0, 4,
         6'd0, 32'h0, 1'b0, 1'b0, acc);
    chk("trunc_fifth_rejected", {31'd0, acc}, 32'd0);

    // reset one cycle after an accept
    do_start(1'b0);
    send(1'b0, FMT_LOAD, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b0, 10,
         6'd0, 32'h00812283, 1'b0, 1'b0, acc);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_idle_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);

    // random valid gaps
    do_start(1'b0);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(1'b0, FMT_RTYPE, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 13'd0, (k == 7), 10,
           6'(k), 32'h003100B3, (k == 7), 1'b0, acc);
      if (!acc) chk("gap_accept_timeout", 32'd0, 32'd1);
    end
    repeat (3) @(negedge clk);

    chk("write_count_eq_accepts", n_wr6, n_acc6);
    chk("q6_drained", q6.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
